// File: rtl/decimal_operand_entry.sv
// Decimal operand entry: debounced ENTER/CLEAR/COMMIT buttons accumulate BCD digits
// into a binary operand that is committed, saturated to WIDTH bits, on COMMIT.
module decimal_operand_entry #(
    parameter int WIDTH           = 4,
    parameter int MAX_DIGITS      = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SYNC_STAGES     = 2,
    localparam int ACC_W = $clog2(10**MAX_DIGITS),
    localparam int CNT_W = $clog2(MAX_DIGITS+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       digit_in,
    input  logic             enter_btn,
    input  logic             clear_btn,
    input  logic             commit_btn,
    output logic [WIDTH-1:0] operand,
    output logic             operand_valid,
    output logic [ACC_W-1:0] entry_value,
    output logic [CNT_W-1:0] digit_count,
    output logic             overflow,
    output logic             error
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES+1);
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(2**WIDTH-1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ENTRY = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam int B_ENTER  = 0;
    localparam int B_CLEAR  = 1;
    localparam int B_COMMIT = 2;

    logic [2:0]             raw;
    logic [SYNC_STAGES-1:0] sync_q [3];
    logic [DB_W-1:0]        db_cnt [3];
    logic [2:0]             level;
    logic [2:0]             level_d;
    logic [2:0]             ev_q;

    assign raw = {commit_btn, clear_btn, enter_btn};

    // Level follows the synchronized input only after DEBOUNCE_CYCLES differing samples;
    // the event is a registered one-cycle pulse on its rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < 3; b++) begin
                sync_q[b] <= '0;
                db_cnt[b] <= '0;
            end
            level   <= '0;
            level_d <= '0;
            ev_q    <= '0;
        end else begin
            for (int unsigned b = 0; b < 3; b++) begin
                sync_q[b] <= {sync_q[b][SYNC_STAGES-2:0], raw[b]};
                if (sync_q[b][SYNC_STAGES-1] == level[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DB_W'(DEBOUNCE_CYCLES-1)) begin
                    level[b]  <= sync_q[b][SYNC_STAGES-1];
                    db_cnt[b] <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + 1'b1;
                end
            end
            level_d <= level;
            ev_q    <= level & ~level_d;
        end
    end

    logic [1:0]       state, state_n;
    logic [ACC_W-1:0] acc_n;
    logic [CNT_W-1:0] cnt_n;
    logic [WIDTH-1:0] op_n;
    logic             vld_n;
    logic             err_n;
    logic [ACC_W+3:0] prod;
    logic [WIDTH-1:0] sat;

    always_comb begin
        prod = ({4'b0000, entry_value} * (ACC_W+4)'(10)) + (ACC_W+4)'(digit_in);
        sat  = (entry_value > SAT_MAX) ? SAT_MAX[WIDTH-1:0] : entry_value[WIDTH-1:0];
    end

    // Priority CLEAR > COMMIT > ENTER; lower-priority events in the same cycle are dropped.
    always_comb begin
        state_n = state;
        acc_n   = entry_value;
        cnt_n   = digit_count;
        op_n    = operand;
        vld_n   = 1'b0;
        err_n   = 1'b0;
        if (ev_q[B_CLEAR]) begin
            acc_n   = '0;
            cnt_n   = '0;
            state_n = IDLE;
        end else if (ev_q[B_COMMIT]) begin
            op_n    = sat;
            vld_n   = 1'b1;
            acc_n   = '0;
            cnt_n   = '0;
            state_n = IDLE;
        end else if (ev_q[B_ENTER]) begin
            if (state == FULL || digit_in > 4'd9) begin
                err_n = 1'b1;
            end else begin
                acc_n   = prod[ACC_W-1:0];
                cnt_n   = digit_count + 1'b1;
                state_n = (cnt_n == CNT_W'(MAX_DIGITS)) ? FULL : ENTRY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            entry_value   <= '0;
            digit_count   <= '0;
            operand       <= '0;
            operand_valid <= 1'b0;
            overflow      <= 1'b0;
            error         <= 1'b0;
        end else begin
            state         <= state_n;
            entry_value   <= acc_n;
            digit_count   <= cnt_n;
            operand       <= op_n;
            operand_valid <= vld_n;
            overflow      <= (acc_n > SAT_MAX);
            error         <= err_n;
        end
    end

endmodule

// File: tb/tb_decimal_operand_entry.sv
// Bench for decimal_operand_entry: fixed vector table, reset/latency sequence, then
// random button presses checked against an integer model of the entry rules.
module tb_decimal_operand_entry;

    localparam int MAXV = 15;
    localparam int MAXD = 2;

    logic       clk;
    logic       rst_n;
    logic [3:0] digit_in;
    logic       enter_btn, clear_btn, commit_btn;
    logic [3:0] operand;
    logic       operand_valid;
    logic [6:0] entry_value;
    logic [1:0] digit_count;
    logic       overflow;
    logic       error;

    decimal_operand_entry #(
        .WIDTH(4), .MAX_DIGITS(2), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digit_in(digit_in),
        .enter_btn(enter_btn), .clear_btn(clear_btn), .commit_btn(commit_btn),
        .operand(operand), .operand_valid(operand_valid),
        .entry_value(entry_value), .digit_count(digit_count),
        .overflow(overflow), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;
    int vld_cyc = 0;
    int err_cyc = 0;

    always @(negedge clk) begin
        if (operand_valid) vld_cyc++;
        if (error) err_cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // mask bit0 = ENTER, bit1 = CLEAR, bit2 = COMMIT
    int v0, e0;
    task automatic press(input logic [2:0] mask, input logic [3:0] d, input int hold);
        @(negedge clk);
        v0 = vld_cyc;
        e0 = err_cyc;
        digit_in = d;
        {commit_btn, clear_btn, enter_btn} = mask;
        repeat (hold) @(negedge clk);
        {commit_btn, clear_btn, enter_btn} = 3'b000;
        repeat (14) @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input int ev, input int ec, input int eo,
                           input int eop, input int evp, input int eep);
        chk({tag, " entry_value"}, int'(entry_value), ev);
        chk({tag, " digit_count"}, int'(digit_count), ec);
        chk({tag, " overflow"}, int'(overflow), eo);
        chk({tag, " operand"}, int'(operand), eop);
        chk({tag, " valid_cycles"}, vld_cyc - v0, evp);
        chk({tag, " error_cycles"}, err_cyc - e0, eep);
    endtask

    typedef struct {
        logic [2:0] mask;
        logic [3:0] d;
        int hold;
        int e_val, e_cnt, e_ovf, e_op, e_vp, e_ep;
    } vec_t;

    vec_t vecs[$];

    // Reference model: plain integer arithmetic of the entry rules.
    int m_acc, m_cnt, m_op, m_vp, m_ep;
    task automatic model(input logic [2:0] mask, input int d);
        m_vp = 0;
        m_ep = 0;
        if (mask[1]) begin
            m_acc = 0; m_cnt = 0;
        end else if (mask[2]) begin
            m_op = (m_acc > MAXV) ? MAXV : m_acc;
            m_vp = 1; m_acc = 0; m_cnt = 0;
        end else if (mask[0]) begin
            if (m_cnt == MAXD || d > 9) m_ep = 1;
            else begin m_acc = m_acc * 10 + d; m_cnt++; end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        digit_in = 4'd0;
        {commit_btn, clear_btn, enter_btn} = 3'b000;

        vecs.push_back('{3'b001, 4'd1, 6,  1, 1, 0, 0, 0, 0});
        vecs.push_back('{3'b001, 4'd2, 6, 12, 2, 0, 0, 0, 0});
        vecs.push_back('{3'b100, 4'd0, 6,  0, 0, 0, 12, 1, 0});
        vecs.push_back('{3'b001, 4'd9, 6,  9, 1, 0, 12, 0, 0});
        vecs.push_back('{3'b001, 4'd9, 6, 99, 2, 1, 12, 0, 0});
        vecs.push_back('{3'b100, 4'd0, 6,  0, 0, 0, 15, 1, 0});
        vecs.push_back('{3'b001, 4'hA, 6,  0, 0, 0, 15, 0, 1});
        vecs.push_back('{3'b001, 4'd3, 6,  3, 1, 0, 15, 0, 0});
        vecs.push_back('{3'b001, 4'd4, 6, 34, 2, 1, 15, 0, 0});
        vecs.push_back('{3'b001, 4'd5, 6, 34, 2, 1, 15, 0, 1});
        vecs.push_back('{3'b010, 4'd0, 6,  0, 0, 0, 15, 0, 0});
        vecs.push_back('{3'b001, 4'd0, 6,  0, 1, 0, 15, 0, 0});
        vecs.push_back('{3'b001, 4'd7, 6,  7, 2, 0, 15, 0, 0});
        vecs.push_back('{3'b110, 4'd0, 6,  0, 0, 0, 15, 0, 0});
        vecs.push_back('{3'b100, 4'd0, 6,  0, 0, 0, 0, 1, 0});
        vecs.push_back('{3'b001, 4'd1, 1,  0, 0, 0, 0, 0, 0});
        vecs.push_back('{3'b001, 4'd1, 2,  0, 0, 0, 0, 0, 0});
        vecs.push_back('{3'b001, 4'd1, 3,  0, 0, 0, 0, 0, 0});
        vecs.push_back('{3'b001, 4'd8, 6,  8, 1, 0, 0, 0, 0});
        vecs.push_back('{3'b101, 4'd3, 6,  0, 0, 0, 8, 1, 0});

        #12;
        chk("reset entry_value", int'(entry_value), 0);
        chk("reset digit_count", int'(digit_count), 0);
        chk("reset operand", int'(operand), 0);
        chk("reset flags", int'({operand_valid, overflow, error}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            press(vecs[i].mask, vecs[i].d, vecs[i].hold);
            chk_all($sformatf("vec%0d", i), vecs[i].e_val, vecs[i].e_cnt, vecs[i].e_ovf,
                    vecs[i].e_op, vecs[i].e_vp, vecs[i].e_ep);
        end

        // Asynchronous reset mid-entry while ENTER is held; the held press must be re-debounced.
        press(3'b001, 4'd5, 6);
        chk("pre-reset entry_value", int'(entry_value), 5);
        digit_in = 4'd3;
        enter_btn = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset entry_value", int'(entry_value), 0);
        chk("async reset operand", int'(operand), 0);
        chk("async reset count/ovf", int'({digit_count, overflow}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("held after reset early", int'(entry_value), 0);
        repeat (10) @(negedge clk);
        chk("held after reset accept", int'(entry_value), 3);
        chk("held after reset count", int'(digit_count), 1);
        enter_btn = 1'b0;
        repeat (14) @(negedge clk);

        m_acc = 3; m_cnt = 1; m_op = 0;
        for (int i = 0; i < 40; i++) begin
            int r;
            logic [2:0] mask;
            logic [3:0] d;
            r = $urandom_range(0, 9);
            if (r <= 5) mask = 3'b001;
            else if (r == 6) mask = 3'b010;
            else if (r <= 8) mask = 3'b100;
            else mask = 3'($urandom_range(1, 7));
            d = 4'($urandom_range(0, 11));
            press(mask, d, int'($urandom_range(4, 8)));
            model(mask, int'(d));
            chk_all($sformatf("rnd%0d", i), m_acc, m_cnt, (m_acc > MAXV) ? 1 : 0,
                    m_op, m_vp, m_ep);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
